// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the L2 controller's address split, state and way encodings.
package lc3b_types;

   typedef logic [15:0] lc3b_pmem_addr;

   localparam int L2_IDX_W  = 3;
   localparam int L2_TAG_W  = 9;
   localparam int L2_OFF_W  = 4;
   localparam int L2_SETS   = 1 << L2_IDX_W;
   localparam int L2_LINE_W = 128;

   typedef logic [L2_TAG_W-1:0]  lc3b_cache_tag;
   typedef logic [L2_IDX_W-1:0]  l2_index_t;
   typedef logic [L2_LINE_W-1:0] l2_line_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } l2_state_t;

   // Encoding matches the LRU bit: lru = 1 names way two as least recently used.
   typedef enum logic {
      WAY_ONE = 1'b0,
      WAY_TWO = 1'b1
   } l2_way_t;

   function automatic l2_index_t l2_index(input lc3b_pmem_addr a);
      return a[L2_OFF_W +: L2_IDX_W];
   endfunction

   function automatic lc3b_cache_tag l2_tag(input lc3b_pmem_addr a);
      return a[L2_OFF_W+L2_IDX_W +: L2_TAG_W];
   endfunction

endpackage

// File: rtl/l2_lru_array.sv
// Per-set LRU bits for the 2-way L2: one bit per set, combinational read, single write port.
module l2_lru_array
   import lc3b_types::*;
(
   input  logic      clk,
   input  logic      reset,
   input  l2_index_t rd_idx_i,
   output logic      rd_lru_o,
   input  logic      we_i,
   input  l2_index_t wr_idx_i,
   input  logic      wr_lru_i
);

   logic [L2_SETS-1:0] lru_q;

   // Clear every set to "way one is LRU" on reset; otherwise update one set when asked.
   always_ff @(posedge clk) begin
      if (reset) begin
         lru_q <= '0;
      end else if (we_i) begin
         lru_q[wr_idx_i] <= wr_lru_i;
      end
   end

   assign rd_lru_o = lru_q[rd_idx_i];

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache control FSM: hit service, victim choice, writeback/allocate handshake and statistics.
module l2_cache_control
   import lc3b_types::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  lc3b_pmem_addr        mem_address,
   output logic                 mem_resp,
   input  logic                 set_one_hit,
   input  logic                 set_two_hit,
   input  logic                 set_one_valid,
   input  logic                 set_two_valid,
   input  logic                 set_one_dirty,
   input  logic                 set_two_dirty,
   input  lc3b_cache_tag        set_one_tag,
   input  lc3b_cache_tag        set_two_tag,
   input  l2_line_t             out_data_set_one_f,
   input  l2_line_t             out_data_set_two_f,
   output logic                 load_set_one,
   output logic                 load_set_two,
   output logic                 write_type_set_one,
   output logic                 write_type_set_two,
   output logic                 input_data_sel,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output lc3b_pmem_addr        pmem_address,
   output l2_line_t             pmem_wdata,
   input  logic                 pmem_resp,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   l2_state_t            state_q, state_d;
   l2_way_t              victim_q, victim_d;
   logic                 pend_q, pend_d;      // request already counted as a miss
   logic [CNT_WIDTH-1:0] hit_q, hit_d;
   logic [CNT_WIDTH-1:0] miss_q, miss_d;

   l2_index_t     idx;
   lc3b_cache_tag victim_tag;
   l2_line_t      victim_line;
   l2_way_t       miss_victim;
   logic          miss_victim_dirty;
   logic          req, hit;
   logic          lru_rd, lru_we, lru_wdata;
   logic          unused_addr;

   assign idx         = l2_index(mem_address);
   assign req         = mem_read | mem_write;
   assign hit         = set_one_hit | set_two_hit;
   assign unused_addr = ^mem_address[L2_OFF_W-1:0];

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   l2_lru_array u_lru (
      .clk      (clk),
      .reset    (reset),
      .rd_idx_i (idx),
      .rd_lru_o (lru_rd),
      .we_i     (lru_we),
      .wr_idx_i (idx),
      .wr_lru_i (lru_wdata)
   );

   // Victim on a miss: fill an invalid way first, otherwise evict the LRU way.
   always_comb begin
      if (!set_one_valid) begin
         miss_victim = WAY_ONE;
      end else if (!set_two_valid) begin
         miss_victim = WAY_TWO;
      end else begin
         miss_victim = l2_way_t'(lru_rd);
      end
      miss_victim_dirty = (miss_victim == WAY_ONE) ? (set_one_valid & set_one_dirty)
                                                   : (set_two_valid & set_two_dirty);
   end

   // The latched victim's stored tag and line feed the writeback.
   assign victim_tag  = (victim_q == WAY_ONE) ? set_one_tag : set_two_tag;
   assign victim_line = (victim_q == WAY_ONE) ? out_data_set_one_f : out_data_set_two_f;

   // State, victim, pending-miss flag and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         victim_q <= WAY_ONE;
         pend_q   <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         pend_q   <= pend_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   // Next state and strobes; everything is held low while reset is asserted so an
   // in-flight WRITEBACK/ALLOCATE cannot load a way or keep a pmem strobe up.
   always_comb begin
      state_d            = state_q;
      victim_d           = victim_q;
      pend_d             = pend_q;
      hit_d              = hit_q;
      miss_d             = miss_q;
      mem_resp           = 1'b0;
      load_set_one       = 1'b0;
      load_set_two       = 1'b0;
      write_type_set_one = 1'b0;
      write_type_set_two = 1'b0;
      input_data_sel     = 1'b0;
      pmem_read          = 1'b0;
      pmem_write         = 1'b0;
      pmem_address       = '0;
      pmem_wdata         = '0;
      lru_we             = 1'b0;
      lru_wdata          = 1'b0;
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (req && hit) begin
                  mem_resp  = 1'b1;
                  pend_d    = 1'b0;
                  lru_we    = 1'b1;
                  lru_wdata = set_one_hit;
                  if (mem_write) begin
                     if (set_one_hit) begin
                        load_set_one       = 1'b1;
                        write_type_set_one = 1'b1;
                     end else begin
                        load_set_two       = 1'b1;
                        write_type_set_two = 1'b1;
                     end
                  end
                  // The re-hit after a fill was already counted as a miss.
                  if (!pend_q) hit_d = sat_inc(hit_q);
               end else if (req) begin
                  victim_d = miss_victim;
                  pend_d   = 1'b1;
                  if (!pend_q) miss_d = sat_inc(miss_q);
                  state_d  = miss_victim_dirty ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               pmem_write   = 1'b1;
               pmem_address = {victim_tag, idx, {L2_OFF_W{1'b0}}};
               pmem_wdata   = victim_line;
               if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
               pmem_read    = 1'b1;
               pmem_address = {mem_address[15:L2_OFF_W], {L2_OFF_W{1'b0}}};
               if (pmem_resp) begin
                  input_data_sel = 1'b1;
                  if (victim_q == WAY_ONE) load_set_one = 1'b1;
                  else                     load_set_two = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: datapath stub, request-level reference model, vector table,
// directed corner sequences and randomized traffic.
module tb_l2_cache_control;

   localparam int CW = 4;   // small counters so saturation is reachable

   logic          clk = 1'b0;
   logic          reset, mem_read, mem_write, mem_resp;
   logic [15:0]   mem_address, pmem_address;
   logic          set_one_hit, set_two_hit, set_one_valid, set_two_valid;
   logic          set_one_dirty, set_two_dirty;
   logic [8:0]    set_one_tag, set_two_tag;
   logic [127:0]  out_data_set_one_f, out_data_set_two_f, pmem_wdata, pmem_rdata, l1_wdata;
   logic          load_set_one, load_set_two, write_type_set_one, write_type_set_two;
   logic          input_data_sel, pmem_read, pmem_write, pmem_resp;
   logic [CW-1:0] hit_count, miss_count;

   always #5 clk = ~clk;

   l2_cache_control #(.CNT_WIDTH(CW)) u_dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_resp(mem_resp),
      .set_one_hit(set_one_hit), .set_two_hit(set_two_hit),
      .set_one_valid(set_one_valid), .set_two_valid(set_two_valid),
      .set_one_dirty(set_one_dirty), .set_two_dirty(set_two_dirty),
      .set_one_tag(set_one_tag), .set_two_tag(set_two_tag),
      .out_data_set_one_f(out_data_set_one_f), .out_data_set_two_f(out_data_set_two_f),
      .load_set_one(load_set_one), .load_set_two(load_set_two),
      .write_type_set_one(write_type_set_one), .write_type_set_two(write_type_set_two),
      .input_data_sel(input_data_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   function automatic logic [127:0] line_of(input logic [15:0] a);
      return {4{a, ~a}};
   endfunction
   assign pmem_rdata = line_of(pmem_address);

   // ---------------- datapath stub: arrays written only by the DUT's load strobes
   logic         dp_clr, ovr, ovr_h1, ovr_h2;
   logic         dp_v [2][8];
   logic         dp_d [2][8];
   logic [8:0]   dp_t [2][8];
   logic [127:0] dp_dat [2][8];
   logic [2:0]   a_idx;
   logic [8:0]   a_tag;
   assign a_idx = mem_address[6:4];
   assign a_tag = mem_address[15:7];

   always_comb begin
      set_one_valid      = dp_v[0][a_idx];
      set_two_valid      = dp_v[1][a_idx];
      set_one_dirty      = dp_d[0][a_idx];
      set_two_dirty      = dp_d[1][a_idx];
      set_one_tag        = dp_t[0][a_idx];
      set_two_tag        = dp_t[1][a_idx];
      out_data_set_one_f = dp_dat[0][a_idx];
      out_data_set_two_f = dp_dat[1][a_idx];
      set_one_hit        = ovr ? ovr_h1 : (dp_v[0][a_idx] && dp_t[0][a_idx] == a_tag);
      set_two_hit        = ovr ? ovr_h2 : (dp_v[1][a_idx] && dp_t[1][a_idx] == a_tag);
   end

   always @(posedge clk) begin
      if (dp_clr) begin
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
               dp_v[w][s] <= 1'b0; dp_d[w][s] <= 1'b0; dp_t[w][s] <= '0; dp_dat[w][s] <= '0;
            end
      end else begin
         if (load_set_one) begin
            dp_v[0][a_idx]   <= 1'b1;
            dp_d[0][a_idx]   <= write_type_set_one;
            dp_t[0][a_idx]   <= a_tag;
            dp_dat[0][a_idx] <= input_data_sel ? pmem_rdata : l1_wdata;
         end
         if (load_set_two) begin
            dp_v[1][a_idx]   <= 1'b1;
            dp_d[1][a_idx]   <= write_type_set_two;
            dp_t[1][a_idx]   <= a_tag;
            dp_dat[1][a_idx] <= input_data_sel ? pmem_rdata : l1_wdata;
         end
      end
   end

   // ---------------- reference model (whole-request granularity)
   bit           ref_v [2][8];
   bit           ref_d [2][8];
   logic [8:0]   ref_t [2][8];
   logic [127:0] ref_dat [2][8];
   int           ref_lru [8];      // way index (0/1) that is least recently used
   int           ref_hits, ref_miss;
   logic [15:0]  last_wb_addr;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic ref_access(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                             output bit hit, output bit wb, output logic [15:0] wb_addr,
                             output logic [127:0] wb_data, output int way);
      int idx;
      logic [8:0] tag;
      idx = int'(addr[6:4]);
      tag = addr[15:7];
      way = -1;
      wb = 0; wb_addr = '0; wb_data = '0;
      for (int w = 0; w < 2; w++) if (ref_v[w][idx] && ref_t[w][idx] == tag) way = w;
      hit = (way >= 0);
      if (hit) begin
         if (ref_hits < (1 << CW) - 1) ref_hits++;
      end else begin
         if (ref_miss < (1 << CW) - 1) ref_miss++;
         if (!ref_v[0][idx])      way = 0;
         else if (!ref_v[1][idx]) way = 1;
         else                     way = ref_lru[idx];
         if (ref_v[way][idx] && ref_d[way][idx]) begin
            wb      = 1;
            wb_addr = {ref_t[way][idx], addr[6:4], 4'h0};
            wb_data = ref_dat[way][idx];
         end
         ref_v[way][idx]   = 1;
         ref_d[way][idx]   = 0;
         ref_t[way][idx]   = tag;
         ref_dat[way][idx] = line_of({addr[15:4], 4'h0});
      end
      if (wr) begin
         ref_d[way][idx]   = 1;
         ref_dat[way][idx] = wd;
      end
      ref_lru[idx] = (way == 0) ? 1 : 0;
   endtask

   // One L1 request held until mem_resp, with randomized pmem latency.
   task automatic do_request(input bit wr, input logic [15:0] addr);
      logic [127:0] wd, exp_wb_data;
      logic [15:0]  exp_wb_addr;
      bit           exp_hit, exp_wb, got_wb, got_fill, done;
      int           exp_way, delay, idx;
      wd = {$urandom, $urandom, $urandom, $urandom};
      ref_access(wr, addr, wd, exp_hit, exp_wb, exp_wb_addr, exp_wb_data, exp_way);
      idx = int'(addr[6:4]);
      @(negedge clk);
      mem_write = wr; mem_read = !wr; mem_address = addr; l1_wdata = wd;
      delay = $urandom_range(0, 3);
      got_wb = 0; got_fill = 0; done = 0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         pmem_resp = 1'b0;
         #1;
         if (pmem_read || pmem_write) begin
            if (delay == 0) begin pmem_resp = 1'b1; delay = $urandom_range(0, 3); end
            else delay--;
         end
         #1;
         chk("single_load", load_set_one & load_set_two, 0);
         chk("single_pmem", pmem_read & pmem_write, 0);
         if (pmem_resp && pmem_write) begin
            got_wb = 1; last_wb_addr = pmem_address;
            chk("wb_addr", pmem_address, exp_wb_addr);
            chk("wb_data", pmem_wdata, exp_wb_data);
         end
         if (pmem_resp && pmem_read) begin
            got_fill = 1;
            chk("fill_addr", pmem_address, {addr[15:4], 4'h0});
            chk("fill_load1", load_set_one, exp_way == 0);
            chk("fill_load2", load_set_two, exp_way == 1);
            chk("fill_wtype", write_type_set_one | write_type_set_two, 0);
            chk("fill_sel", input_data_sel, 1);
         end
         if (mem_resp) begin
            done = 1;
            if (exp_hit) chk("hit_latency", cyc, 0);
            chk("resp_load1", load_set_one, wr && exp_way == 0);
            chk("resp_load2", load_set_two, wr && exp_way == 1);
            chk("resp_wtype1", write_type_set_one, wr && exp_way == 0);
            chk("resp_wtype2", write_type_set_two, wr && exp_way == 1);
            chk("resp_sel", input_data_sel, 0);
         end
      end
      chk("resp_seen", done, 1);
      chk("wb_seen", got_wb, exp_wb);
      chk("fill_seen", got_fill, !exp_hit);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
      #2;
      chk("hit_count", hit_count, ref_hits);
      chk("miss_count", miss_count, ref_miss);
      for (int w = 0; w < 2; w++) begin
         chk("line_valid", dp_v[w][idx], ref_v[w][idx]);
         if (ref_v[w][idx]) begin
            chk("line_tag", dp_t[w][idx], ref_t[w][idx]);
            chk("line_dirty", dp_d[w][idx], ref_d[w][idx]);
            chk("line_data", dp_dat[w][idx], ref_dat[w][idx]);
         end
      end
   endtask

   // ---------------- IDLE-state combinational vector table
   typedef struct {
      string nm;
      bit rd, wr, h1, h2;
      bit resp, l1, l2, wt1, wt2;
   } vec_t;
   vec_t vecs [9];

   initial begin
      bit seen;
      vecs[0] = '{"no_req",    0,0,0,0, 0,0,0,0,0};
      vecs[1] = '{"rd_hit1",   1,0,1,0, 1,0,0,0,0};
      vecs[2] = '{"rd_hit2",   1,0,0,1, 1,0,0,0,0};
      vecs[3] = '{"wr_hit1",   0,1,1,0, 1,1,0,1,0};
      vecs[4] = '{"wr_hit2",   0,1,0,1, 1,0,1,0,1};
      vecs[5] = '{"rdwr_hit2", 1,1,0,1, 1,0,1,0,1};
      vecs[6] = '{"rd_miss",   1,0,0,0, 0,0,0,0,0};
      vecs[7] = '{"wr_miss",   0,1,0,0, 0,0,0,0,0};
      vecs[8] = '{"idle_hit",  0,0,1,0, 0,0,0,0,0};

      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 8; s++) begin
            ref_v[w][s] = 0; ref_d[w][s] = 0; ref_t[w][s] = '0; ref_dat[w][s] = '0;
         end
      for (int s = 0; s < 8; s++) ref_lru[s] = 0;
      ref_hits = 0; ref_miss = 0; last_wb_addr = '0;

      reset = 1'b1; dp_clr = 1'b1; ovr = 1'b0; ovr_h1 = 1'b0; ovr_h2 = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; pmem_resp = 1'b0; l1_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0; dp_clr = 1'b0;
      @(negedge clk); #2;
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
      chk("rst_strobes", {mem_resp, load_set_one, load_set_two, pmem_read, pmem_write}, 0);

      // Vectors are applied and removed between rising edges, so the FSM never acts on them.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         ovr = 1'b1; ovr_h1 = vecs[i].h1; ovr_h2 = vecs[i].h2;
         mem_read = vecs[i].rd; mem_write = vecs[i].wr;
         #1;
         chk({vecs[i].nm, "_resp"}, mem_resp, vecs[i].resp);
         chk({vecs[i].nm, "_load1"}, load_set_one, vecs[i].l1);
         chk({vecs[i].nm, "_load2"}, load_set_two, vecs[i].l2);
         chk({vecs[i].nm, "_wt1"}, write_type_set_one, vecs[i].wt1);
         chk({vecs[i].nm, "_wt2"}, write_type_set_two, vecs[i].wt2);
         chk({vecs[i].nm, "_pmem"}, {pmem_read, pmem_write, input_data_sel}, 0);
         mem_read = 1'b0; mem_write = 1'b0; ovr = 1'b0;
      end

      // Reset while in ALLOCATE, with pmem_resp arriving during and after reset.
      @(negedge clk);
      mem_read = 1'b1; mem_address = 16'h7770;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #2;
         if (pmem_read) begin seen = 1; break; end
      end
      chk("rst_reach_alloc", seen, 1);
      reset = 1'b1; pmem_resp = 1'b1;
      #1;
      chk("rst_alloc_load", {load_set_one, load_set_two}, 0);
      chk("rst_alloc_pread", pmem_read, 0);
      @(negedge clk);
      reset = 1'b0; mem_read = 1'b0;
      #2;
      chk("late_resp_load", {load_set_one, load_set_two}, 0);
      chk("late_resp_pread", {pmem_read, pmem_write}, 0);
      chk("rst_alloc_hits", hit_count, 0);
      chk("rst_alloc_miss", miss_count, 0);
      @(negedge clk);
      pmem_resp = 1'b0;
      #2;
      chk("post_rst_idle", {pmem_read, pmem_write, mem_resp}, 0);
      chk("no_fill_after_rst", dp_v[0][7], 0);

      // Directed sequence on set 3.
      do_request(0, 16'h1230);
      chk("tp_cold_miss", miss_count, 1);
      chk("tp_cold_way1", dp_v[0][3], 1);
      do_request(0, 16'h5630);
      chk("tp_way2_fill", dp_t[1][3], 9'h0AC);
      chk("tp_no_hits", hit_count, 0);
      do_request(1, 16'h1230);
      chk("tp_write_hit", hit_count, 1);
      chk("tp_way1_dirty", dp_d[0][3], 1);
      do_request(0, 16'h5630);            // way one becomes LRU
      do_request(0, 16'h9A30);            // evict dirty way one
      chk("tp_wb_addr", last_wb_addr, 16'h1230);
      chk("tp_refill_clean", dp_d[0][3], 0);
      chk("tp_refill_tag", dp_t[0][3], 9'h134);

      // Saturation of the hit counter.
      for (int i = 0; i < 20; i++) do_request(0, 16'h9A30);
      chk("hit_saturate", hit_count, 4'hF);

      // Randomized traffic over few tags per set to mix hits, fills and writebacks.
      for (int i = 0; i < 150; i++)
         do_request(1'($urandom_range(0, 1)),
                    {7'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15))});
      chk("miss_saturate", miss_count, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
Control FSM for the 2-way, 8-set L2 cache datapath block. Sits beside it between the L1 miss path (upstream) and physical memory (downstream). Consumes per-way hit/valid/dirty/tag/data status from the datapath and drives way loads, write type and input-data select. Owns the per-set LRU bits, the physical-memory handshake, and hit/miss counters.

Parameters:
CNT_WIDTH, 16, width of the saturating hit and miss counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
mem_read  in  1  L1 read request; held until mem_resp
mem_write  in  1  L1 write request (full line); held until mem_resp
mem_address  in  16  L1 request address (lc3b_pmem_addr)
mem_resp  out  1  one-cycle completion pulse to L1
set_one_hit, set_two_hit  in  1 each  per-way hit from datapath
set_one_valid, set_two_valid  in  1 each  per-way valid bit at the indexed set
set_one_dirty, set_two_dirty  in  1 each  per-way dirty bit at the indexed set
set_one_tag, set_two_tag  in  9 each  per-way stored tag (lc3b_cache_tag)
out_data_set_one_f, out_data_set_two_f  in  128 each  per-way stored line
load_set_one, load_set_two  out  1 each  way write enables
write_type_set_one, write_type_set_two  out  1 each  1 = L1 write (set dirty), 0 = fill (clear dirty)
input_data_sel  out  1  datapath input mux: 0 = L1 write data, 1 = pmem_rdata
pmem_read, pmem_write  out  1 each  physical-memory strobes; held until pmem_resp
pmem_address  out  16  line-aligned physical address
pmem_wdata  out  128  writeback line
pmem_resp  in  1  physical-memory completion
hit_count, miss_count  out  CNT_WIDTH  saturating statistics

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. Reset -> IDLE; all outputs 0; lru[0..7] = 0; victim register = way one; counters = 0.
- Datapath read is combinational, so hit service takes one cycle.
- IDLE, no request: all strobes 0.
- IDLE, request and hit:
  - mem_resp = 1 in the same cycle.
  - On write: assert load of the hitting way, write_type = 1, input_data_sel = 0.
  - lru[index] <= 1 if way one hit, 0 if way two hit (lru = 1 means way two is LRU).
  - hit_count++.
- IDLE, request and miss:
  - Victim selection: way one if invalid; else way two if invalid; else the way named by lru[index].
  - Latch the victim and miss_count++.
  - Next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - mem_resp = 0.
- WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, index, 4'b0}, pmem_wdata = victim line.
  - On pmem_resp -> ALLOCATE.
- ALLOCATE:
  - pmem_read = 1, pmem_address = {mem_address[15:4], 4'b0}.
  - On pmem_resp: load the victim way, write_type = 0, input_data_sel = 1, then -> IDLE.
  - The held request then hits in IDLE and updates the LRU (write-allocate; a write completes as a hit).
- Counters saturate at all-ones; no wrap.
- Only one counter increments per request. A request is counted once, at first miss detection or at a direct hit. A post-fill re-hit is not counted.
- load_set_one and load_set_two are never both 1.
- pmem_read and pmem_write are never both 1.
- Reset mid-WRITEBACK or mid-ALLOCATE: state returns to IDLE next cycle, strobes drop, no way load. A late pmem_resp arriving in IDLE is ignored.
- Simultaneous mem_read and mem_write is illegal. Write takes precedence.

Decomposition:
- lc3b_types gains the l2_state_t enum (IDLE/WRITEBACK/ALLOCATE), an l2_way_t typedef, and the L2 index/tag/offset width constants (3/9/4).
- Sub-module l2_lru_array: 8×1-bit array with synchronous reset, a read port, and a write port.

Test Plan:
- Reset, then read 0x1230 -> miss_count = 1, pmem_read with pmem_address 0x1230. After pmem_resp: load_set_one = 1, write_type = 0. Next cycle mem_resp = 1, lru[3] = 1.
- Read 0x1230, then read 0x5630 (same index 3) -> fill goes to way two (invalid). lru[3] = 0. hit_count stays 0.
- Write 0x1230 (hit, way one) -> mem_resp in the same cycle, load_set_one = 1, write_type_set_one = 1, hit_count++.
- With way one dirty (tag 0x024) and LRU, read 0x9A30 -> pmem_write to 0x1230 with the way-one line. Then pmem_read 0x9A30. Way one is refilled with write_type = 0.
- Assert reset during ALLOCATE, then pulse pmem_resp -> state IDLE, no load_set_*, pmem_read = 0, counters = 0.
- Force hit_count to 0xFFFF, then perform a hit -> hit_count remains 0xFFFF.
